ascon_permutation_sequencer: RTL

//  Round controller for the ASCON permutation datapath (constant addition, substitution, linear layer).

---
 rtl/ascon_permutation_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/ascon_permutation_sequencer.sv
// Round controller for the ASCON permutation: sequences p^a / p^b round
// indices and the state-register select/enable for the round datapath.
module ascon_permutation_sequencer #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6,
    parameter int ROUND_W     = 4
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic               abort_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               data_sel_o,
    output logic               en_state_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN,
        DONE
    } state_t;

    localparam logic [ROUND_W-1:0] LAST    = ROUND_W'(NB_ROUNDS_A - 1);
    localparam logic [ROUND_W-1:0] START_B = ROUND_W'(NB_ROUNDS_A - NB_ROUNDS_B);

    state_t             state;
    logic [ROUND_W-1:0] cnt;
    logic               mode_q;
    logic               one_round;
    logic               last_round;

    // A single-round permutation finishes straight out of FIRST
    assign one_round  = mode_q ? (NB_ROUNDS_B == 1) : (NB_ROUNDS_A == 1);
    assign last_round = (state == FIRST) ? one_round : (cnt == LAST);
    assign round_o    = cnt;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state      <= IDLE;
            cnt        <= '0;
            mode_q     <= 1'b0;
            data_sel_o <= 1'b0;
            en_state_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= FIRST;
                        cnt        <= mode_i ? START_B : '0;
                        mode_q     <= mode_i;
                        data_sel_o <= 1'b1;
                        en_state_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                FIRST, RUN: begin
                    data_sel_o <= 1'b0;
                    if (abort_i) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        en_state_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else if (last_round) begin
                        state      <= DONE;
                        en_state_o <= 1'b0;
                        done_o     <= 1'b1;
                    end else begin
                        state      <= RUN;
                        cnt        <= cnt + ROUND_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    data_sel_o <= 1'b0;
                    en_state_o <= 1'b0;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule
